// File: rtl/painterengine_gpu_dma_writer_mc.sv
// -----------------------------------------------------------------------------
// painterengine_gpu_dma_writer_mc
//
// AXI4 write-DMA master serving N_CH source streams. A start pulse selects one
// channel (one-hot router) and moves that channel's beats to memory, starting at
// its base address, split into INCR bursts. A burst never exceeds MAX_BURST beats
// and never crosses a 4 KB boundary. Only one burst is outstanding at any time,
// and AW and W never overlap. A bad B response or a stalled handshake ends the job
// with an error code.
//
// Optional feature macro: PAINTERENGINE_GPU_DMA_WRITER_STATS_EN
//   When defined, this adds o_wire_beat_count / o_wire_burst_count. Both clear on
//   start and saturate at their maximum value.
//
// Ports
//   i_wire_clock / i_wire_resetn   clock, asynchronous active-low reset
//   i_wire_start                   1-cycle job start pulse (ignored while busy)
//   i_wire_router [N_CH]           one-hot channel select, sampled on start
//   i_wire_address/length [32*N]   per-channel byte base address / length in beats
//   i_wire_data/data_valid         per-channel stream
//   o_wire_data_next [N_CH]        per-channel pop strobe (beat accepted)
//   o_wire_busy/done/error         job status; error_type: 0 ok, 1 router,
//                                  2 addr/len, 3 bresp, 4 timeout
//   o_wire_M_AXI_AW*/W*/B*         AXI4 write channels
// -----------------------------------------------------------------------------
module painterengine_gpu_dma_writer_mc #(
   parameter int N_CH      = 4,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 256,
   parameter int TIMEOUT_W = 16
) (
   input  logic                     i_wire_clock,
   input  logic                     i_wire_resetn,
   input  logic                     i_wire_start,
   input  logic [N_CH-1:0]          i_wire_router,
   input  logic [32*N_CH-1:0]       i_wire_address,
   input  logic [32*N_CH-1:0]       i_wire_length,
   input  logic [DATA_W*N_CH-1:0]   i_wire_data,
   input  logic [N_CH-1:0]          i_wire_data_valid,
   output logic [N_CH-1:0]          o_wire_data_next,
   output logic                     o_wire_busy,
   output logic                     o_wire_done,
   output logic                     o_wire_error,
   output logic [2:0]               o_wire_error_type,
`ifdef PAINTERENGINE_GPU_DMA_WRITER_STATS_EN
   output logic [31:0]              o_wire_beat_count,
   output logic [15:0]              o_wire_burst_count,
`endif
   output logic [3:0]               o_wire_M_AXI_AWID,
   output logic [31:0]              o_wire_M_AXI_AWADDR,
   output logic [7:0]               o_wire_M_AXI_AWLEN,
   output logic [2:0]               o_wire_M_AXI_AWSIZE,
   output logic [1:0]               o_wire_M_AXI_AWBURST,
   output logic [3:0]               o_wire_M_AXI_AWCACHE,
   output logic                     o_wire_M_AXI_AWVALID,
   input  logic                     i_wire_M_AXI_AWREADY,
   output logic [DATA_W-1:0]        o_wire_M_AXI_WDATA,
   output logic [DATA_W/8-1:0]      o_wire_M_AXI_WSTRB,
   output logic                     o_wire_M_AXI_WLAST,
   output logic                     o_wire_M_AXI_WVALID,
   input  logic                     i_wire_M_AXI_WREADY,
   output logic                     o_wire_M_AXI_BREADY,
   input  logic [3:0]               i_wire_M_AXI_BID,
   input  logic [1:0]               i_wire_M_AXI_BRESP,
   input  logic                     i_wire_M_AXI_BVALID
);

   localparam int BYTES      = DATA_W / 8;
   localparam int BYTES_LOG2 = $clog2(BYTES);
   localparam int IDX_W      = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_CALC  = 3'd2,
      ST_AW    = 3'd3,
      ST_W     = 3'd4,
      ST_B     = 3'd5,
      ST_DONE  = 3'd6,
      ST_ERROR = 3'd7
   } state_t;

   state_t                  state_r, state_nx_s;
   logic [N_CH-1:0]         router_r;
   logic [IDX_W-1:0]        sel_r;
   logic [31:0]             addr_r, len_r, offset_r, cur_r, blen_r, beat_r;
   logic [TIMEOUT_W-1:0]    timer_r;
   logic [2:0]              error_type_r;

   logic                    start_ok_s;
   logic [IDX_W-1:0]        start_idx_s;
   logic [31:0]             start_addr_s, start_len_s;
   logic                    onehot_s, addr_len_ok_s;
   logic [31:0]             cur_s, room_s, remain_s, blen_s, blen_m1_s;
   logic                    aw_hs_s, w_valid_s, w_hs_s, b_hs_s, wlast_s, bresp_err_s;
   logic                    stall_s, tmo_s;
   logic [TIMEOUT_W-1:0]    timer_nx_s;
   logic                    unused_s;

   // BID is not needed: with a single outstanding burst every response is ours.
   assign unused_s = ^i_wire_M_AXI_BID;

   assign start_ok_s = i_wire_start &&
                       ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR));

   // Lowest set router bit selects whose address/length get latched at start.
   always_comb begin
      start_idx_s = {IDX_W{1'b0}};
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (i_wire_router[i]) begin
            start_idx_s = IDX_W'(i);
         end else begin
            start_idx_s = start_idx_s;
         end
      end
   end

   assign start_addr_s = i_wire_address[{start_idx_s, 5'd0} +: 32];
   assign start_len_s  = i_wire_length[{start_idx_s, 5'd0} +: 32];

   assign onehot_s      = (router_r != {N_CH{1'b0}}) &&
                          ((router_r & (router_r - N_CH'(1))) == {N_CH{1'b0}});
   assign addr_len_ok_s = (addr_r[BYTES_LOG2-1:0] == {BYTES_LOG2{1'b0}}) && (len_r != 32'd0);

   // Burst sizing: the smallest of MAX_BURST, the beats left, and the beats up to the next 4 KB page.
   // room_s is at least 1 because cur is always beat aligned.
   always_comb begin
      cur_s    = addr_r + (offset_r << BYTES_LOG2);
      room_s   = (32'd4096 - {20'd0, cur_s[11:0]}) >> BYTES_LOG2;
      remain_s = len_r - offset_r;
      blen_s   = 32'(MAX_BURST);
      if (remain_s < blen_s) begin
         blen_s = remain_s;
      end else begin
         blen_s = blen_s;
      end
      if (room_s < blen_s) begin
         blen_s = room_s;
      end else begin
         blen_s = blen_s;
      end
   end

   assign blen_m1_s   = blen_r - 32'd1;
   assign aw_hs_s     = (state_r == ST_AW) && i_wire_M_AXI_AWREADY;
   assign w_valid_s   = (state_r == ST_W) && i_wire_data_valid[sel_r];
   assign w_hs_s      = w_valid_s && i_wire_M_AXI_WREADY;
   assign wlast_s     = (beat_r == blen_m1_s);
   assign b_hs_s      = (state_r == ST_B) && i_wire_M_AXI_BVALID;
   assign bresp_err_s = (i_wire_M_AXI_BRESP >= 2'd2);

   // A stall is any AW/W/B cycle without that channel's handshake.
   assign stall_s    = ((state_r == ST_AW) && !aw_hs_s) ||
                       ((state_r == ST_W)  && !w_hs_s)  ||
                       ((state_r == ST_B)  && !b_hs_s);
   assign timer_nx_s = timer_r + TIMEOUT_W'(1);
   assign tmo_s      = stall_s && (timer_nx_s == {TIMEOUT_W{1'b1}});

   // State register.
   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (i_wire_start) begin
               state_nx_s = ST_CHECK;
            end else begin
               state_nx_s = state_r;
            end
         end
         ST_CHECK: begin
            if (!onehot_s || !addr_len_ok_s) begin
               state_nx_s = ST_ERROR;
            end else begin
               state_nx_s = ST_CALC;
            end
         end
         ST_CALC: state_nx_s = ST_AW;
         ST_AW: begin
            if (tmo_s) begin
               state_nx_s = ST_ERROR;
            end else if (aw_hs_s) begin
               state_nx_s = ST_W;
            end else begin
               state_nx_s = ST_AW;
            end
         end
         ST_W: begin
            if (tmo_s) begin
               state_nx_s = ST_ERROR;
            end else if (w_hs_s && wlast_s) begin
               state_nx_s = ST_B;
            end else begin
               state_nx_s = ST_W;
            end
         end
         ST_B: begin
            if (tmo_s) begin
               state_nx_s = ST_ERROR;
            end else if (b_hs_s && bresp_err_s) begin
               state_nx_s = ST_ERROR;
            end else if (b_hs_s && (offset_r == len_r)) begin
               state_nx_s = ST_DONE;
            end else if (b_hs_s) begin
               state_nx_s = ST_CALC;
            end else begin
               state_nx_s = ST_B;
            end
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Job datapath: latched job parameters, burst position, timeout counter and error code.
   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         router_r     <= {N_CH{1'b0}};
         sel_r        <= {IDX_W{1'b0}};
         addr_r       <= 32'd0;
         len_r        <= 32'd0;
         offset_r     <= 32'd0;
         cur_r        <= 32'd0;
         blen_r       <= 32'd0;
         beat_r       <= 32'd0;
         timer_r      <= {TIMEOUT_W{1'b0}};
         error_type_r <= 3'd0;
      end else if (start_ok_s) begin
         router_r     <= i_wire_router;
         sel_r        <= start_idx_s;
         addr_r       <= start_addr_s;
         len_r        <= start_len_s;
         offset_r     <= 32'd0;
         timer_r      <= {TIMEOUT_W{1'b0}};
         error_type_r <= 3'd0;
      end else begin
         case (state_r)
            ST_CHECK: begin
               if (!onehot_s) begin
                  error_type_r <= 3'd1;
               end else if (!addr_len_ok_s) begin
                  error_type_r <= 3'd2;
               end else begin
                  error_type_r <= 3'd0;
               end
            end
            ST_CALC: begin
               cur_r   <= cur_s;
               blen_r  <= blen_s;
               timer_r <= {TIMEOUT_W{1'b0}};
            end
            ST_AW: begin
               if (aw_hs_s) begin
                  beat_r  <= 32'd0;
                  timer_r <= {TIMEOUT_W{1'b0}};
               end else begin
                  timer_r <= timer_nx_s;
                  if (tmo_s) error_type_r <= 3'd4;
               end
            end
            ST_W: begin
               if (w_hs_s) begin
                  beat_r  <= beat_r + 32'd1;
                  timer_r <= {TIMEOUT_W{1'b0}};
                  if (wlast_s) offset_r <= offset_r + blen_r;
               end else begin
                  timer_r <= timer_nx_s;
                  if (tmo_s) error_type_r <= 3'd4;
               end
            end
            ST_B: begin
               if (b_hs_s) begin
                  timer_r <= {TIMEOUT_W{1'b0}};
                  if (bresp_err_s) error_type_r <= 3'd3;
               end else begin
                  timer_r <= timer_nx_s;
                  if (tmo_s) error_type_r <= 3'd4;
               end
            end
            default: begin
               timer_r <= timer_r;
            end
         endcase
      end
   end

   // Outputs decode from the state register, so an asynchronous reset clears them at once.
   always_comb begin
      o_wire_data_next     = {N_CH{1'b0}};
      o_wire_busy          = 1'b0;
      o_wire_done          = 1'b0;
      o_wire_error         = 1'b0;
      o_wire_error_type    = error_type_r;
      o_wire_M_AXI_AWID    = 4'd0;
      o_wire_M_AXI_AWADDR  = 32'd0;
      o_wire_M_AXI_AWLEN   = 8'd0;
      o_wire_M_AXI_AWSIZE  = 3'd0;
      o_wire_M_AXI_AWBURST = 2'b00;
      o_wire_M_AXI_AWCACHE = 4'b0000;
      o_wire_M_AXI_AWVALID = 1'b0;
      o_wire_M_AXI_WDATA   = {DATA_W{1'b0}};
      o_wire_M_AXI_WSTRB   = {BYTES{1'b0}};
      o_wire_M_AXI_WLAST   = 1'b0;
      o_wire_M_AXI_WVALID  = 1'b0;
      o_wire_M_AXI_BREADY  = 1'b0;
      case (state_r)
         ST_CHECK, ST_CALC: o_wire_busy = 1'b1;
         ST_AW: begin
            o_wire_busy          = 1'b1;
            o_wire_M_AXI_AWADDR  = cur_r;
            o_wire_M_AXI_AWLEN   = blen_m1_s[7:0];
            o_wire_M_AXI_AWSIZE  = 3'(BYTES_LOG2);
            o_wire_M_AXI_AWBURST = 2'b01;
            o_wire_M_AXI_AWCACHE = 4'b0010;
            o_wire_M_AXI_AWVALID = 1'b1;
         end
         ST_W: begin
            o_wire_busy             = 1'b1;
            o_wire_M_AXI_WDATA      = i_wire_data[sel_r*DATA_W +: DATA_W];
            o_wire_M_AXI_WSTRB      = {BYTES{1'b1}};
            o_wire_M_AXI_WLAST      = wlast_s;
            o_wire_M_AXI_WVALID     = w_valid_s;
            o_wire_data_next[sel_r] = w_hs_s;
         end
         ST_B: begin
            o_wire_busy         = 1'b1;
            o_wire_M_AXI_BREADY = 1'b1;
         end
         ST_DONE:  o_wire_done  = 1'b1;
         ST_ERROR: o_wire_error = 1'b1;
         default:  o_wire_busy  = 1'b0;
      endcase
   end

`ifdef PAINTERENGINE_GPU_DMA_WRITER_STATS_EN
   logic [31:0] beat_count_r;
   logic [15:0] burst_count_r;

   // Saturating per-job counters of W and B handshakes.
   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         beat_count_r  <= 32'd0;
         burst_count_r <= 16'd0;
      end else if (start_ok_s) begin
         beat_count_r  <= 32'd0;
         burst_count_r <= 16'd0;
      end else begin
         if (w_hs_s && (beat_count_r != 32'hFFFF_FFFF)) beat_count_r <= beat_count_r + 32'd1;
         if (b_hs_s && (burst_count_r != 16'hFFFF)) burst_count_r <= burst_count_r + 16'd1;
      end
   end

   assign o_wire_beat_count  = beat_count_r;
   assign o_wire_burst_count = burst_count_r;
`endif

endmodule
